// File: rtl/seq_shifter_pkg.sv
// Shared types for the multi-cycle shifter.
// Modes, FSM states and the reserved-mode test.
package shift_pkg;

  typedef enum logic [2:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic is_reserved(logic [2:0] m);
    return m > 3'd4;
  endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// Request/result bundle between a client and seq_shifter.
// Sized by the operand width n.
interface seq_shifter_if #(
  parameter int n = 8
);
  logic                 en;
  logic                 start;
  logic [2:0]           mode;
  logic [$clog2(n)-1:0] amt;
  logic [n-1:0]         in;
  logic [n-1:0]         out;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output en, start, mode, amt, in,
    input  out, busy, done, err
  );

  modport slave (
    input  en, start, mode, amt, in,
    output out, busy, done, err
  );
endinterface

// File: rtl/seq_shifter_step.sv
// One shift step of up to `step` positions.
// Purely combinational; reserved modes pass work through.
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int n    = 8,
  parameter int step = 1
) (
  input  logic [n-1:0]                work,
  input  logic [2:0]                  mode,
  input  logic [$clog2(step+1)-1:0]   k,
  output logic [n-1:0]                res
);

  logic [2*n-1:0] dbl;

  always_comb begin
    dbl = '0;
    res = work;
    case (mode)
      SLL: res = work << k;
      SRL: res = work >> k;
      SRA: res = $unsigned($signed(work) >>> k);
      ROL: begin
        dbl = {work, work} << k;
        res = dbl[2*n-1:n];
      end
      ROR: begin
        dbl = {work, work} >> k;
        res = dbl[n-1:0];
      end
      default: res = work;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: latches a request, shifts up to
// `step` bits per enabled clock, pulses done with the result.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int n    = 8,
  parameter int step = 1
) (
  input  logic          clk,
  input  logic          rst,
  seq_shifter_if.slave  bus
);

  localparam int aw = $clog2(n);
  localparam int kw = $clog2(step + 1);
  localparam logic [aw-1:0] stepw = aw'(step);

  state_e         state, state_n;
  logic [n-1:0]   work, work_n;
  logic [n-1:0]   out_q, out_n;
  logic [n-1:0]   shifted;
  logic [aw-1:0]  rem, rem_n;
  logic [aw-1:0]  kx;
  logic [2:0]     mode_q, mode_n;
  logic           err_q, err_n;

  assign kx = (rem > stepw) ? stepw : rem;

  shift_step_unit #(
    .n    (n),
    .step (step)
  ) u_step (
    .work (work),
    .mode (mode_q),
    .k    (kw'(kx)),
    .res  (shifted)
  );

  assign bus.out  = out_q;
  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.err  = err_q;

  always_comb begin
    state_n = state;
    work_n  = work;
    rem_n   = rem;
    mode_n  = mode_q;
    out_n   = out_q;
    err_n   = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (bus.start) begin
          work_n = bus.in;
          rem_n  = bus.amt;
          mode_n = bus.mode;
          // nothing to shift: finish on the accept edge
          if (bus.amt == '0 || is_reserved(bus.mode)) begin
            state_n = DONE;
            out_n   = bus.in;
            err_n   = is_reserved(bus.mode);
          end else begin
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_n = shifted;
        rem_n  = rem - kx;
        if (rem == kx) begin
          out_n   = shifted;
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      work   <= '0;
      rem    <= '0;
      mode_q <= '0;
      out_q  <= '0;
      err_q  <= 1'b0;
    end else if (bus.en) begin
      state  <= state_n;
      work   <= work_n;
      rem    <= rem_n;
      mode_q <= mode_n;
      out_q  <= out_n;
      err_q  <= err_n;
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: step=1 and step=3
// instances share stimulus, each with its own expectations.
module tb_seq_shifter;

  typedef struct {
    logic [7:0] out;
    logic       err;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  exp_t q1[$];
  exp_t q3[$];

  seq_shifter_if #(.n(8)) i1 ();
  seq_shifter_if #(.n(8)) i3 ();

  assign i3.en    = i1.en;
  assign i3.start = i1.start;
  assign i3.mode  = i1.mode;
  assign i3.amt   = i1.amt;
  assign i3.in    = i1.in;

  seq_shifter #(.n(8), .step(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (i1.slave)
  );

  seq_shifter #(.n(8), .step(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (i3.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_shift(logic [7:0] x, logic [2:0] m, int a);
    logic signed [7:0] s;
    s = x;
    case (m)
      3'd0: return x << a;
      3'd1: return x >> a;
      3'd2: return s >>> a;
      3'd3: return (x << a) | (x >> (8 - a));
      3'd4: return (x >> a) | (x << (8 - a));
      default: return x;
    endcase
  endfunction

  function automatic int lat(logic [2:0] m, int a, int st);
    if (m > 3'd4) return 0;
    return (a + st - 1) / st;
  endfunction

  task automatic push(logic [7:0] x, logic [2:0] m, int a, int e0, int extra);
    exp_t e;
    e.out = ref_shift(x, m, a);
    e.err = (m > 3'd4);
    e.due = e0 + lat(m, a, 1) + extra;
    q1.push_back(e);
    e.due = e0 + lat(m, a, 3) + extra;
    q3.push_back(e);
  endtask

  task automatic issue(logic [7:0] x, logic [2:0] m, int a, int extra);
    @(negedge clk);
    i1.start = 1'b1;
    i1.in    = x;
    i1.mode  = m;
    i1.amt   = 3'(a);
    @(posedge clk);
    #1;
    push(x, m, a, cyc, extra);
    i1.start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q1.delete();
    q3.delete();
  endtask

  task automatic wait_idle(int bound);
    int i = 0;
    while ((q1.size() != 0 || q3.size() != 0) && i < bound) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("drain", q1.size() + q3.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (i1.done) begin
      if (q1.size() == 0) check("d1_extra", 1, 0);
      else begin
        e = q1.pop_front();
        check("d1_out", i1.out, e.out);
        check("d1_err", i1.err, e.err);
        check("d1_cyc", cyc, e.due);
      end
    end else check("d1_err_low", i1.err, 0);
    if (i3.done) begin
      if (q3.size() == 0) check("d3_extra", 1, 0);
      else begin
        e = q3.pop_front();
        check("d3_out", i3.out, e.out);
        check("d3_err", i3.err, e.err);
        check("d3_cyc", cyc, e.due);
      end
    end else check("d3_err_low", i3.err, 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int e0;
    i1.en = 1'b1;
    i1.start = 1'b0;
    i1.mode = 3'd0;
    i1.amt = 3'd0;
    i1.in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out1", i1.out, 0);
    check("rst_busy1", i1.busy, 0);
    check("rst_done1", i1.done, 0);
    check("rst_err1", i1.err, 0);
    check("rst_out3", i3.out, 0);
    check("rst_busy3", i3.busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // SLL with busy count
    issue(8'h03, 3'd0, 3, 0);
    nb = 0;
    repeat (5) begin
      @(negedge clk);
      if (i1.busy) nb++;
    end
    check("t1_busy", nb, 3);
    wait_idle(20);

    do_reset();
    issue(8'h80, 3'd2, 2, 0);
    wait_idle(20);
    do_reset();
    issue(8'h80, 3'd1, 2, 0);
    wait_idle(20);

    do_reset();
    issue(8'h81, 3'd3, 7, 0);
    wait_idle(20);
    do_reset();
    issue(8'h01, 3'd4, 1, 0);
    wait_idle(20);
    issue(8'hB5, 3'd2, 6, 0);
    wait_idle(20);

    // zero amount and reserved modes finish on the accept edge
    do_reset();
    for (int m = 0; m < 8; m++) begin
      issue(8'h5A, 3'(m), (m > 4) ? 4 : 0, 0);
      check("t4_busy1", i1.busy, 0);
      check("t4_busy3", i3.busy, 0);
      check("t4_done1", i1.done, 1);
    end
    wait_idle(20);

    // start while busy ignored, two stall cycles
    do_reset();
    issue(8'h0F, 3'd4, 5, 2);
    @(negedge clk);
    i1.start = 1'b1;
    i1.in = 8'hFF;
    i1.mode = 3'd0;
    i1.amt = 3'd1;
    @(negedge clk);
    i1.start = 1'b0;
    i1.en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i1.en = 1'b1;
    wait_idle(30);

    // start held through DONE: back-to-back accept
    do_reset();
    @(negedge clk);
    i1.start = 1'b1;
    i1.in = 8'h11;
    i1.mode = 3'd0;
    i1.amt = 3'd1;
    @(posedge clk);
    #1;
    e0 = cyc;
    push(8'h11, 3'd0, 1, e0, 0);
    i1.in = 8'h05;
    i1.mode = 3'd1;
    i1.amt = 3'd2;
    @(posedge clk);
    @(posedge clk);
    #1;
    push(8'h05, 3'd1, 2, e0 + 2, 0);
    i1.start = 1'b0;
    check("b2b_busy1", i1.busy, 1);
    check("b2b_busy3", i3.busy, 1);
    wait_idle(20);

    // reset mid-shift
    do_reset();
    issue(8'h03, 3'd0, 3, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mr_out1", i1.out, 0);
    check("mr_busy1", i1.busy, 0);
    check("mr_done1", i1.done, 0);
    check("mr_err1", i1.err, 0);
    check("mr_out3", i3.out, 0);
    rst = 1'b0;
    q1.delete();
    q3.delete();

    // reset overrides en=0
    issue(8'h81, 3'd0, 5, 0);
    @(negedge clk);
    i1.en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ro_busy1", i1.busy, 0);
    check("ro_busy3", i3.busy, 0);
    check("ro_out1", i1.out, 0);
    @(negedge clk);
    rst = 1'b0;
    i1.en = 1'b1;
    q1.delete();
    q3.delete();
    issue(8'hC3, 3'd3, 4, 0);
    wait_idle(20);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
